// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional access-fault reporting is enabled by defining IMEM_ERR_EN.
package imem_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 10;
  localparam logic [31:0] NOP            = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_resp_if.sv
// Fetch-stage request/response bundle between the fetch unit (master)
// and the instruction memory (slave).
interface imem_resp_if;

  logic        req;
  logic [31:0] inst_a;
  logic [31:0] inst_r;
  logic        inst_v;
  logic        busy;

  modport master (
    output req, inst_a,
    input  inst_r, inst_v, busy
  );

  modport slave (
    input  req, inst_a,
    output inst_r, inst_v, busy
  );

endinterface

// File: rtl/imem_ram.sv
// Instruction storage: synchronous loader write port, combinational read port.
// Contents are intentionally not reset.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_resp.sv
// Instruction memory with fixed-latency single-outstanding fetch response.
// Define IMEM_ERR_EN to add the err port and fault checking on fetch addresses.
module imem_resp
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned WAIT       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_resp_if.slave            fetch,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
`ifdef IMEM_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam logic [3:0] WAIT_L = 4'(WAIT);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx_nxt;
  logic [31:0]           r_inst;
  logic [31:0]           w_rdata;
  logic [31:0]           w_word;
  logic                  w_resp;

  imem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (ld_we),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

`ifdef IMEM_ERR_EN
  logic r_fault, w_fault_nxt, w_fault_req;

  assign w_fault_req = (|fetch.inst_a[1:0]) | (|fetch.inst_a[31:DEPTH_LOG2+2]);
  assign w_word      = r_fault ? NOP : w_rdata;
  assign err         = w_resp & r_fault;
`else
  logic w_unused;

  assign w_unused = ^{fetch.inst_a[1:0], fetch.inst_a[31:DEPTH_LOG2+2]};
  assign w_word   = w_rdata;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
`ifdef IMEM_ERR_EN
    w_fault_nxt = r_fault;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (fetch.req) begin
          w_idx_nxt   = fetch.inst_a[DEPTH_LOG2+1:2];
          w_cnt_nxt   = WAIT_L;
`ifdef IMEM_ERR_EN
          w_fault_nxt = w_fault_req;
`endif
          w_state_nxt = (WAIT_L != '0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The word is read combinationally during RESP so a loader write in that
  // same cycle lands after the read, while writes in earlier cycles are seen.
  assign w_resp       = (r_state == S_RESP);
  assign fetch.inst_v = w_resp;
  assign fetch.busy   = (r_state != S_IDLE);
  assign fetch.inst_r = w_resp ? w_word : r_inst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_inst  <= '0;
`ifdef IMEM_ERR_EN
      r_fault <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
`ifdef IMEM_ERR_EN
      r_fault <= w_fault_nxt;
`endif
      if (w_resp) begin
        r_inst <= w_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_resp.sv
// Self-checking bench for imem_resp: two instances (WAIT=2 and WAIT=0)
// compared against a word-array model with latency derived from WAIT.
module tb_imem_resp;

  localparam int unsigned DL2   = 10;
  localparam int unsigned DEPTH = 1 << DL2;
  localparam int unsigned W2    = 2;
  localparam int unsigned W0    = 0;

  logic            clk;
  logic            rst_n;
  logic            ld_we;
  logic [DL2-1:0]  ld_addr;
  logic [31:0]     ld_data;
`ifdef IMEM_ERR_EN
  logic            err2, err0;
`endif

  imem_resp_if f2 ();
  imem_resp_if f0 ();

  imem_resp #(.DEPTH_LOG2(DL2), .WAIT(W2)) dut2 (
    .clk(clk), .reset(rst_n), .fetch(f2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_ERR_EN
    , .err(err2)
`endif
  );

  imem_resp #(.DEPTH_LOG2(DL2), .WAIT(W0)) dut0 (
    .clk(clk), .reset(rst_n), .fetch(f0),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_ERR_EN
    , .err(err0)
`endif
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] model [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic model_fault(input logic [31:0] a);
`ifdef IMEM_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (model_fault(a)) return 32'h0;
    return model[(a >> 2) % DEPTH];
  endfunction

  function automatic logic err2_val();
`ifdef IMEM_ERR_EN
    return err2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic ld(input int unsigned idx, input logic [31:0] data);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = DL2'(idx); ld_data = data;
    @(negedge clk);
    ld_we = 1'b0;
    model[idx] = data;
  endtask

  // Issues one request on the WAIT=2 instance; returns at the negedge where inst_v is seen.
  task automatic req2(input logic [31:0] a, output int lat, output logic [31:0] d,
                      output logic e, output logic busy_ok);
    @(negedge clk);
    f2.req = 1'b1; f2.inst_a = a;
    @(negedge clk);
    f2.req = 1'b0;
    lat = 0; d = 'x; e = 1'bx; busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (f2.inst_v === 1'b1) begin
        lat = k; d = f2.inst_r; e = err2_val();
        break;
      end
      if (f2.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({f2.inst_v, f2.busy, f0.inst_v, f0.busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {f2.inst_v, f2.busy, f0.inst_v, f0.busy});
    end
    checks++;
    if (f2.inst_r !== 32'h0 || f0.inst_r !== 32'h0) begin
      failures++;
      $display("FAIL reset_inst_r got=%h/%h want=0", f2.inst_r, f0.inst_r);
    end
`ifdef IMEM_ERR_EN
    checks++;
    if ({err2, err0} !== 2'b00) begin
      failures++;
      $display("FAIL reset_err got=%b want=00", {err2, err0});
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int lat; logic [31:0] d; logic e, bok; logic [31:0] a;
    req2(32'h4, lat, d, e, bok);
    checks++;
    if (lat != int'(W2 + 1) || d !== 32'h2008_0005 || bok !== 1'b1) begin
      failures++;
      $display("FAIL first_read lat=%0d data=%h busy_ok=%b want lat=%0d data=20080005 busy_ok=1",
               lat, d, bok, W2 + 1);
    end
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 63)) << 2;
      req2(a, lat, d, e, bok);
      checks++;
      if (lat != int'(W2 + 1) || d !== model_word(a) || e !== 1'b0 || bok !== 1'b1) begin
        failures++;
        $display("FAIL rand_read a=%h lat=%0d data=%h err=%b want lat=%0d data=%h err=0",
                 a, lat, d, e, W2 + 1, model_word(a));
      end
    end
    @(negedge clk);
    checks++;
    if (f2.inst_v !== 1'b0 || f2.busy !== 1'b0 || f2.inst_r !== d) begin
      failures++;
      $display("FAIL hold_after_resp v=%b busy=%b r=%h want v=0 busy=0 r=%h",
               f2.inst_v, f2.busy, f2.inst_r, d);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    int nv;
    a = 32'($urandom_range(0, 31)) << 2;
    b = 32'($urandom_range(32, 63)) << 2;
    @(negedge clk); f2.req = 1'b1; f2.inst_a = a;
    @(negedge clk); f2.inst_a = b;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (f2.inst_v !== 1'b1 || f2.inst_r !== model_word(a)) begin
      failures++;
      $display("FAIL busy_first v=%b r=%h want v=1 r=%h", f2.inst_v, f2.inst_r, model_word(a));
    end
    @(negedge clk);
    checks++;
    if (f2.busy !== 1'b0 || f2.inst_v !== 1'b0) begin
      failures++;
      $display("FAIL busy_resp_req busy=%b v=%b want 0 0", f2.busy, f2.inst_v);
    end
    f2.req = 1'b0;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (f2.inst_v === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin
      failures++;
      $display("FAIL busy_ignored extra_resp=%0d want 0", nv);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    @(negedge clk); f0.req = 1'b1; f0.inst_a = addrs[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (f0.inst_v !== 1'b1 || f0.inst_r !== model_word(addrs[k])) begin
        failures++;
        $display("FAIL b2b_w0 k=%0d v=%b r=%h want v=1 r=%h", k, f0.inst_v, f0.inst_r,
                 model_word(addrs[k]));
      end
      if (k < 2) f0.inst_a = addrs[k + 1];
      @(negedge clk);
      checks++;
      if (f0.inst_v !== 1'b0) begin
        failures++;
        $display("FAIL b2b_w0_gap k=%0d v=%b want 0", k, f0.inst_v);
      end
    end
    f0.req = 1'b0;
    // WAIT=2 instance with req held: response every WAIT+2 cycles
    for (int k = 0; k < 3; k++) addrs[k] = 32'($urandom_range(0, 63)) << 2;
    @(negedge clk); f2.req = 1'b1; f2.inst_a = addrs[0];
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= int'(W2 + 2); c++) begin
        @(negedge clk);
        checks++;
        if (c == int'(W2 + 1)) begin
          if (f2.inst_v !== 1'b1 || f2.inst_r !== model_word(addrs[k])) begin
            failures++;
            $display("FAIL b2b_w2 k=%0d c=%0d v=%b r=%h want v=1 r=%h", k, c, f2.inst_v,
                     f2.inst_r, model_word(addrs[k]));
          end
          if (k < 2) f2.inst_a = addrs[k + 1];
          else f2.req = 1'b0;
        end else if (f2.inst_v !== 1'b0) begin
          failures++;
          $display("FAIL b2b_w2_gap k=%0d c=%0d v=%b want 0", k, c, f2.inst_v);
        end
      end
    end
  endtask

  task automatic test_ld_collision();
    int unsigned idx;
    logic [31:0] oldv, newv;
    idx  = $urandom_range(0, 63);
    oldv = model[idx];
    newv = ~oldv ^ $urandom;
    @(negedge clk); f2.req = 1'b1; f2.inst_a = idx << 2;
    @(negedge clk); f2.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (f2.inst_v !== 1'b1 || f2.inst_r !== oldv) begin
      failures++;
      $display("FAIL ld_in_resp v=%b r=%h want v=1 r=%h", f2.inst_v, f2.inst_r, oldv);
    end
    ld_we = 1'b1; ld_addr = DL2'(idx); ld_data = newv;
    @(negedge clk);
    ld_we = 1'b0; model[idx] = newv;
    checks++;
    if (f2.inst_v !== 1'b0 || f2.inst_r !== oldv) begin
      failures++;
      $display("FAIL ld_in_resp_hold v=%b r=%h want v=0 r=%h", f2.inst_v, f2.inst_r, oldv);
    end
    // write during each WAIT cycle in turn: the new word must come back
    for (int wc = 1; wc <= int'(W2); wc++) begin
      newv = $urandom;
      @(negedge clk); f2.req = 1'b1; f2.inst_a = idx << 2;
      for (int c = 1; c <= int'(W2 + 1); c++) begin
        @(negedge clk);
        f2.req = 1'b0;
        ld_we = (c == wc);
        ld_addr = DL2'(idx); ld_data = newv;
      end
      model[idx] = newv;
      checks++;
      if (f2.inst_v !== 1'b1 || f2.inst_r !== newv) begin
        failures++;
        $display("FAIL ld_in_wait wc=%0d v=%b r=%h want v=1 r=%h", wc, f2.inst_v, f2.inst_r, newv);
      end
      ld_we = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int nv; int lat; logic [31:0] d; logic e, bok;
    @(negedge clk); f2.req = 1'b1; f2.inst_a = 32'h4;
    @(negedge clk); f2.req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (f2.inst_v !== 1'b0 || f2.busy !== 1'b0 || f2.inst_r !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid v=%b busy=%b r=%h want 0 0 0", f2.inst_v, f2.busy, f2.inst_r);
    end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      if (f2.inst_v === 1'b1 || f2.busy === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin
      failures++;
      $display("FAIL reset_abort active_cycles=%0d want 0", nv);
    end
    req2(32'h4, lat, d, e, bok);
    checks++;
    if (lat != int'(W2 + 1) || d !== model[1]) begin
      failures++;
      $display("FAIL mem_kept lat=%0d data=%h want lat=%0d data=%h", lat, d, W2 + 1, model[1]);
    end
  endtask

  task automatic test_addr_rules();
    int lat; logic [31:0] d; logic e, bok; logic [31:0] a;
    logic [31:0] list [4];
`ifdef IMEM_ERR_EN
    list[0] = 32'h0000_0006; list[1] = 32'h0001_0000;
    list[2] = 32'h8; list[3] = 32'($urandom_range(1, 3)) | (32'($urandom_range(0, 63)) << 2);
`else
    list[0] = 32'h0000_1004;
    for (int i = 1; i < 4; i++)
      list[i] = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 63)) << 2);
`endif
    for (int i = 0; i < 4; i++) begin
      a = list[i];
      req2(a, lat, d, e, bok);
      checks++;
      if (lat != int'(W2 + 1) || d !== model_word(a) || e !== model_fault(a)) begin
        failures++;
        $display("FAIL addr_rule a=%h lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
                 a, lat, d, e, W2 + 1, model_word(a), model_fault(a));
      end
    end
  endtask

  initial begin
    f2.req = 1'b0; f2.inst_a = '0;
    f0.req = 1'b0; f0.inst_a = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    for (int i = 0; i < 64; i++) ld(i, $urandom);
    ld(1, 32'h2008_0005);
    test_single_read();
    test_busy_ignore();
    test_back_to_back();
    test_ld_collision();
    test_reset_mid();
    test_addr_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, meaning log2 of memory depth in 32-bit words (1024 words).
REQ-002 Parameter WAIT, default 2, meaning wait cycles between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  fetch-stage read request strobe.
REQ-006 inst_a  input  32  byte address of instruction, driven by the fetch stage.
REQ-007 inst_r  output  32  instruction word returned to the fetch stage.
REQ-008 inst_v  output  1  one-cycle pulse marking inst_r valid.
REQ-009 busy  output  1  high while a request is outstanding; new requests ignored.
REQ-010 ld_we  input  1  loader write enable, program image preload.
REQ-011 ld_addr  input  DEPTH_LOG2  loader word address.
REQ-012 ld_data  input  32  loader write data.
REQ-013 err  output  1  access fault flag; present only when IMEM_ERR_EN is defined.

Function
REQ-014 FSM states IDLE, WAIT, RESP; IDLE is the reset state.
REQ-015 IDLE: req=1 captures inst_a into an address register, loads the wait counter with WAIT, sets busy; goes to WAIT if WAIT>0, else RESP.
REQ-016 WAIT: counter decrements each cycle; on reaching 1 goes to RESP.
REQ-017 RESP: inst_r drives the addressed word, inst_v=1 for exactly one cycle, busy drops at the end of the cycle, returns to IDLE.
REQ-018 Latency: inst_v asserts WAIT+1 cycles after the accepting edge.
REQ-019 req while busy=1 is ignored, not queued; req in the RESP cycle is also ignored.
REQ-020 inst_r holds its last value when inst_v=0.
REQ-021 Word index = captured inst_a[DEPTH_LOG2+1:2].
REQ-022 Loader writes occur on any cycle regardless of state; a write to the word being read in the RESP cycle returns the pre-write word; a write in any earlier cycle of the transaction returns the new word.
REQ-023 Back-to-back: req held high yields one response every WAIT+2 cycles.

Reset
REQ-024 reset low forces state IDLE, inst_r=0, inst_v=0, busy=0, err=0, counter=0 immediately.
REQ-025 Reset during WAIT or RESP aborts the transaction; no inst_v is issued after release.
REQ-026 Memory contents are not cleared by reset.

Configuration
REQ-027 Macro IMEM_ERR_EN: defined -> misaligned (inst_a[1:0]!=0) or out-of-range (inst_a[31:DEPTH_LOG2+2]!=0) requests still complete with normal latency but return inst_r=32'h0000_0000 (NOP) with err=1 in the inst_v cycle; err=0 otherwise.
REQ-028 IMEM_ERR_EN undefined -> no err port; inst_a[1:0] ignored and upper address bits alias (wrap modulo depth).

Structure
REQ-029 Package imem_pkg holds the state enum typedef, default DEPTH_LOG2, and NOP constant 32'h0000_0000.
REQ-030 Sub-module imem_ram holds the storage array: synchronous write port (loader), combinational read port.

Verification
REQ-031 Reset low mid-WAIT (WAIT=2) -> inst_v, busy drop immediately; after release no inst_v appears.
REQ-032 Load word 1 = 32'h2008_0005, req with inst_a=4, WAIT=2 -> inst_v high exactly 3 cycles later, inst_r=32'h2008_0005.
REQ-033 WAIT=0, req held high over addresses 0,4,8 -> one inst_v every 2 cycles with the matching loaded words.
REQ-034 Second req issued while busy -> ignored; only the first address is answered.
REQ-035 ld_we to the pending address during the RESP cycle -> old word returned; repeat in WAIT cycle -> new word returned.
REQ-036 IMEM_ERR_EN defined, inst_a=32'h0000_0006 and 32'h0001_0000 -> inst_r=0, err=1; undefined, inst_a=32'h0000_1004 -> word 1 returned.
